// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shift_pipe op encoding and single-level shift function (SHIFT_PIPE_ROTATE_EN enables ROR)
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    // Widest datapath the shared level function supports
    localparam int SHIFT_MAX_W = 64;

    // One mux level: shift the low 'width' bits of d by 'sh' according to op.
    // Bits above 'width' are assumed zero on entry and are cleared on exit.
    function automatic logic [SHIFT_MAX_W-1:0] shift_level(
        input logic [SHIFT_MAX_W-1:0] d,
        input logic                   sign,
        input shift_op_t              op,
        input int                     width,
        input int                     sh
    );
        logic [SHIFT_MAX_W-1:0] m;
        logic [SHIFT_MAX_W-1:0] r;
        m = ~({SHIFT_MAX_W{1'b1}} << width);
        case (op)
            OP_SLL:  r = (d << sh) & m;
            OP_SRA:  r = (d >> sh) | ({SHIFT_MAX_W{sign}} & m & ~(m >> sh));
`ifdef SHIFT_PIPE_ROTATE_EN
            OP_ROR:  r = ((d >> sh) | (d << (width - sh))) & m;
`endif
            // SRL, and op 11 when rotate is not built
            default: r = d >> sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one barrel-shifter level with its registers and local handshake (SHIFT_PIPE_ROTATE_EN)
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int LEVEL = 0
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(WIDTH):0]   i_amt,
    input  shift_op_t                i_op,
    input  logic                     i_sign,
    input  logic [TAG_W-1:0]         i_tag,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(WIDTH):0]   o_amt,
    output shift_op_t                o_op,
    output logic                     o_sign,
    output logic [TAG_W-1:0]         o_tag
);

    localparam int LOG2W = $clog2(WIDTH);

    logic                   r_valid;
    logic [WIDTH-1:0]       r_data;
    logic [LOG2W:0]         r_amt;
    shift_op_t              r_op;
    logic                   r_sign;
    logic [TAG_W-1:0]       r_tag;

    logic                   w_rot;
    logic [WIDTH-1:0]       w_pre;
    logic [WIDTH-1:0]       w_next;
    logic [LOG2W:0]         w_amt;
    logic [SHIFT_MAX_W-1:0] w_ext;

    // Over-range resolution (level 0 only), then this level's conditional shift by 2^LEVEL
    always_comb begin
        w_rot = 1'b0;
`ifdef SHIFT_PIPE_ROTATE_EN
        w_rot = (i_op == OP_ROR);
`endif
        w_pre = i_data;
        w_amt = i_amt;
        if (LEVEL == 0 && i_amt[LOG2W]) begin
            if (w_rot) begin
                w_amt[LOG2W] = 1'b0;
            end else begin
                w_amt = '0;
                w_pre = (i_op == OP_SRA) ? {WIDTH{i_sign}} : '0;
            end
        end
        w_ext  = SHIFT_MAX_W'(w_pre);
        w_next = w_pre;
        if (w_amt[LEVEL]) begin
            w_next = WIDTH'(shift_level(w_ext, i_sign, i_op, WIDTH, 1 << LEVEL));
        end
    end

    // Stage register: loads when empty or when downstream takes the current item
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_op    <= OP_SLL;
            r_sign  <= 1'b0;
            r_tag   <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_next;
                r_amt  <= w_amt;
                r_op   <= i_op;
                r_sign <= i_sign;
                r_tag  <= i_tag;
            end
        end
    end

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;
    assign o_op    = r_op;
    assign o_sign  = r_sign;
    assign o_tag   = r_tag;

endmodule

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter with valid/ready and tag sideband (SHIFT_PIPE_ROTATE_EN enables ROR)
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [$clog2(WIDTH):0] in_amt,
    input  logic [1:0]             in_op,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy
);

    localparam int LOG2W = $clog2(WIDTH);

    // Index 0 is the block input; index g+1 is the output of stage g
    logic [LOG2W:0]   w_valid;
    logic [LOG2W:0]   w_sign;
    logic [WIDTH-1:0] w_data [0:LOG2W];
    logic [LOG2W:0]   w_amt  [0:LOG2W];
    shift_op_t        w_op   [0:LOG2W];
    logic [TAG_W-1:0] w_tag  [0:LOG2W];
    logic             w_unused;

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_amt[0]   = in_amt;
    assign w_op[0]    = shift_op_t'(in_op);
    assign w_sign[0]  = in_data[WIDTH-1];
    assign w_tag[0]   = in_tag;

    // Ready is kept per generate scope so the out_ready -> in_ready chain is a plain AND/OR ladder
    for (genvar g = 0; g < LOG2W; g++) begin : g_stage
        logic w_rdy;
        logic w_dn_rdy;

        if (g == LOG2W - 1) begin : g_last
            assign w_dn_rdy = out_ready;
        end else begin : g_mid
            assign w_dn_rdy = g_stage[g+1].w_rdy;
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .LEVEL (g)
        ) u_stage (
            .Clk     (Clk),
            .Rst_n   (Rst_n),
            .i_valid (w_valid[g]),
            .o_ready (w_rdy),
            .i_data  (w_data[g]),
            .i_amt   (w_amt[g]),
            .i_op    (w_op[g]),
            .i_sign  (w_sign[g]),
            .i_tag   (w_tag[g]),
            .i_ready (w_dn_rdy),
            .o_valid (w_valid[g+1]),
            .o_data  (w_data[g+1]),
            .o_amt   (w_amt[g+1]),
            .o_op    (w_op[g+1]),
            .o_sign  (w_sign[g+1]),
            .o_tag   (w_tag[g+1])
        );
    end

    assign in_ready  = g_stage[0].w_rdy;
    assign out_valid = w_valid[LOG2W];
    assign out_data  = w_data[LOG2W];
    assign out_tag   = w_tag[LOG2W];
    assign busy      = |w_valid[LOG2W:1];

    // Final-stage amount/op/sign are bookkeeping only
    assign w_unused  = ^{w_amt[LOG2W], w_op[LOG2W], w_sign[LOG2W]};

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - directed self-checking bench for shift_pipe at WIDTH=8
module tb_shift_pipe;
    import shift_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_amt;
    logic [1:0] in_op;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_tag;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] d;
        logic [3:0] amt;
        logic [7:0] exp;
    } vec_t;

    shift_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive one item into an idle pipe and observe it at the output (no checking here)
    task automatic send_one(input logic [1:0] op, input logic [7:0] d, input logic [3:0] amt,
                            input logic [3:0] tag, output int lat, output logic [7:0] od,
                            output logic [3:0] ot);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = amt;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        od = out_data;
        ot = out_tag;
        tick();
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_shift();
        vec_t v [7] = '{
            '{OP_SRA, 8'h90, 4'd2, 8'hE4},
            '{OP_SLL, 8'h81, 4'd1, 8'h02},
            '{OP_SRL, 8'hF0, 4'd7, 8'h01},
            '{OP_SLL, 8'h01, 4'd7, 8'h80},
            '{OP_SRA, 8'h80, 4'd7, 8'hFF},
            '{OP_SRA, 8'h5A, 4'd0, 8'h5A},
            '{OP_SRL, 8'hB4, 4'd3, 8'h16}
        };
        int lat; logic [7:0] od; logic [3:0] ot;
        for (int i = 0; i < 7; i++) begin
            send_one(v[i].op, v[i].d, v[i].amt, 4'(i + 1), lat, od, ot);
            checks++; if (lat !== 3) begin errors++; $display("FAIL shift_latency[%0d] got %0d want 3", i, lat); end
            checks++; if (od !== v[i].exp) begin errors++; $display("FAIL shift_data[%0d] got %h want %h", i, od, v[i].exp); end
            checks++; if (ot !== 4'(i + 1)) begin errors++; $display("FAIL shift_tag[%0d] got %0d want %0d", i, ot, i + 1); end
        end
    endtask

    task automatic test_overrange();
        vec_t v [5] = '{
            '{OP_SRL, 8'hFF, 4'd9,  8'h00},
            '{OP_SRA, 8'h80, 4'd12, 8'hFF},
            '{OP_SLL, 8'h01, 4'd8,  8'h00},
            '{OP_SRA, 8'h7F, 4'd15, 8'h00},
            '{OP_SRA, 8'hC0, 4'd8,  8'hFF}
        };
        int lat; logic [7:0] od; logic [3:0] ot;
        for (int i = 0; i < 5; i++) begin
            send_one(v[i].op, v[i].d, v[i].amt, 4'(i + 8), lat, od, ot);
            checks++; if (lat !== 3) begin errors++; $display("FAIL ovr_latency[%0d] got %0d want 3", i, lat); end
            checks++; if (od !== v[i].exp) begin errors++; $display("FAIL ovr_data[%0d] got %h want %h", i, od, v[i].exp); end
            checks++; if (ot !== 4'(i + 8)) begin errors++; $display("FAIL ovr_tag[%0d] got %0d want %0d", i, ot, i + 8); end
        end
    endtask

    task automatic test_rotate();
`ifdef SHIFT_PIPE_ROTATE_EN
        vec_t v [4] = '{
            '{OP_ROR, 8'h81, 4'd1,  8'hC0},
            '{OP_ROR, 8'h81, 4'd9,  8'hC0},
            '{OP_ROR, 8'h12, 4'd4,  8'h21},
            '{OP_ROR, 8'hB4, 4'd15, 8'h69}
        };
`else
        vec_t v [4] = '{
            '{OP_ROR, 8'h81, 4'd1,  8'h40},
            '{OP_ROR, 8'h81, 4'd9,  8'h00},
            '{OP_ROR, 8'h12, 4'd4,  8'h01},
            '{OP_ROR, 8'hB4, 4'd15, 8'h00}
        };
`endif
        int lat; logic [7:0] od; logic [3:0] ot;
        for (int i = 0; i < 4; i++) begin
            send_one(v[i].op, v[i].d, v[i].amt, 4'(i + 3), lat, od, ot);
            checks++; if (lat !== 3) begin errors++; $display("FAIL rot_latency[%0d] got %0d want 3", i, lat); end
            checks++; if (od !== v[i].exp) begin errors++; $display("FAIL rot_data[%0d] got %h want %h", i, od, v[i].exp); end
        end
    endtask

    task automatic test_backpressure();
        int next = 1;
        int recv = 0;
        int gaps = 0;
        logic acc, emit;
        in_op = OP_SLL; in_amt = 4'd0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_tag = 4'(next); in_data = 8'(next);
            #1;
            if (c >= 3) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, in_ready); end
                checks++; if (out_tag !== 4'd1) begin errors++; $display("FAIL bp_hold_tag[%0d] got %0d want 1", c, out_tag); end
                checks++; if (out_data !== 8'd1) begin errors++; $display("FAIL bp_hold_data[%0d] got %h want 01", c, out_data); end
            end
            acc = in_ready;
            tick();
            if (acc) next++;
        end
        checks++; if (next - 1 !== 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", next - 1); end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && recv < 5; c++) begin
            in_valid = (next <= 5); in_tag = 4'(next); in_data = 8'(next);
            #1;
            acc  = in_valid && in_ready;
            emit = out_valid;
            if (!out_valid) gaps++;
            if (emit) begin
                checks++; if (out_tag !== 4'(recv + 1)) begin errors++; $display("FAIL bp_order got %0d want %0d", out_tag, recv + 1); end
            end
            tick();
            if (acc) next++;
            if (emit) recv++;
        end
        in_valid = 1'b0;
        checks++; if (recv !== 5) begin errors++; $display("FAIL bp_received got %0d want 5", recv); end
        checks++; if (gaps !== 0) begin errors++; $display("FAIL bp_gaps got %0d want 0", gaps); end
    endtask

    task automatic test_bubbles();
        logic [3:0] q [$];
        logic [3:0] exp_tag;
        int sent = 0;
        int recv = 0;
        logic acc, emit;
        in_op = OP_SLL; in_amt = 4'd0;
        for (int c = 0; c < 200 && recv < 8; c++) begin
            in_valid  = (c % 2 == 0) && (sent < 8);
            in_tag    = 4'(sent + 1);
            in_data   = 8'(sent + 1);
            out_ready = (c % 3 != 0);
            #1;
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (emit) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bub_spurious got tag %0d want none", out_tag);
                end else begin
                    exp_tag = q.pop_front();
                    if (out_tag !== exp_tag || out_data !== {4'h0, exp_tag}) begin
                        errors++; $display("FAIL bub_item got tag %0d data %h want tag %0d", out_tag, out_data, exp_tag);
                    end
                end
            end
            if (acc) q.push_back(in_tag);
            tick();
            if (acc) sent++;
            if (emit) recv++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (recv !== 8) begin errors++; $display("FAIL bub_received got %0d want 8", recv); end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL bub_leftover got %0d want 0", q.size()); end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        int lat; logic [7:0] od; logic [3:0] ot;
        out_ready = 1'b1; in_op = OP_SRL; in_amt = 4'd1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_tag = 4'(9 + c); in_data = 8'hF0;
            tick();
        end
        in_valid = 1'b0;
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_out_data got %h want 00", out_data); end
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_ghost_items got %0d want 0", seen); end
        send_one(OP_SLL, 8'h03, 4'd2, 4'd7, lat, od, ot);
        checks++; if (od !== 8'h0C || ot !== 4'd7) begin errors++; $display("FAIL mid_recover got %h/%0d want 0c/7", od, ot); end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_overrange();
        test_rotate();
        test_backpressure();
        test_bubbles();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
